// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue -- single-issue sequencer for an external, registered 4-bit ALU.
//
// Decodes a 12-bit instruction, reads two operands from a four-entry 4-bit
// register file, presents them to the external ALU, waits one cycle for the
// ALU to capture, then writes the result (and flags / MUL high nibble) back.
// One ALU instruction occupies IDLE -> EXEC -> WB, i.e. one op per 3 cycles.
//
// Instruction layout: [11:9] opn, [8:7] rd, [6:5] rs1, [4:3] rs2, [3:0] imm.
// Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110 LT,
//          111 LDI (or NOP, see below).
//
// Build option:
//   ALU_ISSUE_LDI_EN  defined   : opcode 111 loads imm into r[rd] at accept.
//                     undefined : opcode 111 is a NOP (still pulses done).
//   Either way opcode 111 completes in one cycle and the FSM stays in IDLE.
//
// Parameters:
//   REG_RST  reset value of r0..r3
//   OPW      ALU opcode width (fixed at 3)
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset, wins over everything
//   instr        instruction word
//   instr_valid  instr is presented
//   instr_ready  high only in IDLE; accept = instr_valid & instr_ready
//   alu_a/alu_b  registered operands, held until the next ALU accept
//   alu_opn      registered opcode, held until the next ALU accept
//   alu_out0     ALU result (valid one cycle after operands change)
//   alu_out1     ALU MUL high nibble
//   status       ALU status: [1] carry/borrow, [2] less-than
//   done         one-cycle pulse when an instruction retires
//   flag_c       carry/borrow from the last ADD/SUB
//   flag_lt      result of the last LT
//   hi           high nibble of the last MUL
//   dbg_sel      register-file debug read select
//   dbg_data     combinational r[dbg_sel]
// ---------------------------------------------------------------------------
module alu_issue #(
  parameter logic [3:0] REG_RST = 4'h0,
  parameter int         OPW     = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [11:0]    instr,
  input  logic           instr_valid,
  output logic           instr_ready,
  output logic [3:0]     alu_a,
  output logic [3:0]     alu_b,
  output logic [OPW-1:0] alu_opn,
  input  logic [3:0]     alu_out0,
  input  logic [3:0]     alu_out1,
  input  logic [3:0]     status,
  output logic           done,
  output logic           flag_c,
  output logic           flag_lt,
  output logic [3:0]     hi,
  input  logic [1:0]     dbg_sel,
  output logic [3:0]     dbg_data
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_MUL = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR = OPW'(5);
  localparam logic [OPW-1:0] OP_LT  = OPW'(6);
  localparam logic [OPW-1:0] OP_LDI = OPW'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  state_e state, state_nxt;

  // Instruction fields. imm overlaps rs2[0]; only LDI looks at it.
  logic [OPW-1:0] dec_opn;
  logic [1:0]     dec_rd;
  logic [1:0]     dec_rs1;
  logic [1:0]     dec_rs2;
  logic [3:0]     dec_imm;

  assign dec_opn = instr[11:9];
  assign dec_rd  = instr[8:7];
  assign dec_rs1 = instr[6:5];
  assign dec_rs2 = instr[4:3];
  assign dec_imm = instr[3:0];

  logic accept;
  logic alu_go;   // accepted instruction that goes through the external ALU
  logic ldi_go;   // accepted single-cycle opcode 111

  assign accept = (state == S_IDLE) && instr_valid;
  assign alu_go = accept && (dec_opn != OP_LDI);
  assign ldi_go = accept && (dec_opn == OP_LDI);

  // Architectural state
  logic [3:0] regs [4];
  logic [1:0] rd_q;
  logic       done_q;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order; within one block
    // the last non-blocking assignment to a signal wins.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and ready
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    state_nxt   = state;
    instr_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (alu_go) state_nxt = S_EXEC;
      end
      // The external ALU captures during EXEC; nothing can stall it.
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: operand issue, write-back, flags, done
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this four-entry register file is architectural state with a
      // defined reset value, so it is reset like ordinary flops; a true RAM
      // array would be left unreset.
      for (int i = 0; i < 4; i++) regs[i] <= REG_RST;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_opn <= OP_ADD;
      rd_q    <= '0;
      hi      <= '0;
      flag_c  <= 1'b0;
      flag_lt <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Operands are read at the accept edge, so a write-back at an earlier
      // edge is already visible, and rd == rs uses the pre-write value.
      if (alu_go) begin
        alu_a   <= regs[dec_rs1];
        alu_b   <= regs[dec_rs2];
        alu_opn <= dec_opn;
        rd_q    <= dec_rd;
      end

      // Opcode 111 retires in the cycle after accept without leaving IDLE.
      if (ldi_go) begin
        done_q <= 1'b1;
`ifdef ALU_ISSUE_LDI_EN
        regs[dec_rd] <= dec_imm;
`endif
      end

      // Entering WB: the ALU result becomes valid, announce retirement.
      if (state == S_EXEC) done_q <= 1'b1;

      // alu_opn still holds the opcode of the instruction in flight.
      if (state == S_WB) begin
        case (alu_opn)
          OP_ADD, OP_SUB: begin
            regs[rd_q] <= alu_out0;
            flag_c     <= status[1];
          end
          OP_MUL: begin
            regs[rd_q] <= alu_out0;
            hi         <= alu_out1;
          end
          OP_AND, OP_OR, OP_XOR: regs[rd_q] <= alu_out0;
          OP_LT:                 flag_lt    <= status[2];
          default: ;
        endcase
      end
    end
  end

  // Reset during the WB cycle cancels the write-back at the end of that
  // cycle, so the retirement pulse is suppressed in the same cycle as well.
  assign done = done_q && !rst;

  assign dbg_data = regs[dbg_sel];

  // Status bits 0 and 3 carry nothing this block needs; imm is only consumed
  // when the load option is built in.
  logic unused_bits;
  assign unused_bits = ^{status[3], status[0], dec_imm};

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue -- self-checking bench for alu_issue.
//
// Contains a registered stand-in for the external ALU, a behavioural model of
// the architectural state (register file, hi, flags, issued operands), a
// table of directed vectors with hand-computed expectations, several
// multi-cycle reset / handshake sequences, and a randomized instruction run.
// ---------------------------------------------------------------------------
module tb_alu_issue;

  localparam logic [3:0] RR = 4'hC;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  alu_a, alu_b;
  logic [2:0]  alu_opn;
  logic [3:0]  alu_out0 = '0;
  logic [3:0]  alu_out1 = '0;
  logic [3:0]  status = '0;
  logic        done, flag_c, flag_lt;
  logic [3:0]  hi;
  logic [1:0]  dbg_sel = '0;
  logic [3:0]  dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_r [4];
  int m_hi, m_c, m_lt, m_a, m_b, m_op;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  rd, rs1, rs2;
    logic [3:0]  imm;
    logic [15:0] regs;   // {r3, r2, r1, r0}
    logic [3:0]  hi;
    logic        c, lt;
  } vec_t;

  always #5 clk = ~clk;

  alu_issue #(.REG_RST(RR), .OPW(3)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_opn(alu_opn),
    .alu_out0(alu_out0), .alu_out1(alu_out1), .status(status), .done(done),
    .flag_c(flag_c), .flag_lt(flag_lt), .hi(hi), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
  );

  // External ALU stand-in. Outputs an op does not define carry deliberately
  // misleading values so that a write or flag update on the wrong op shows.
  function automatic logic [11:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    int r;
    logic [3:0] o0, o1, st;
    o0 = ~a;
    o1 = a ^ b;
    st = {1'b0, ~(a < b), a[0] ^ b[0], 1'b0};
    case (op)
      OP_ADD: begin r = int'(a) + int'(b); o0 = 4'(r); st[1] = (r > 15); end
      OP_SUB: begin r = int'(a) - int'(b); o0 = 4'(r); st[1] = (a < b); end
      OP_MUL: begin r = int'(a) * int'(b); o0 = 4'(r); o1 = 4'(r >> 4); end
      OP_AND: o0 = a & b;
      OP_OR:  o0 = a | b;
      OP_XOR: o0 = a ^ b;
      OP_LT:  st[2] = (a < b);
      default: ;
    endcase
    st[0] = (o0 == 4'h0);
    return {st, o1, o0};
  endfunction

  always @(posedge clk) {status, alu_out1, alu_out0} <= alu_fn(alu_a, alu_b, alu_opn);

  function automatic logic [11:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2,
                                      input logic [3:0] imm, input logic [2:0] jk);
    if (op == OP_LDI) return {op, rd, jk, imm};
    return {op, rd, rs1, rs2, jk};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 4; j++) m_r[j] = int'(RR);
    m_hi = 0; m_c = 0; m_lt = 0; m_a = 0; m_b = 0; m_op = 0;
  endtask

  task automatic model_exec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic [3:0] imm);
    int a, b;
    a = m_r[rs1];
    b = m_r[rs2];
    if (op != OP_LDI) begin m_a = a; m_b = b; m_op = int'(op); end
    case (op)
      OP_ADD: begin m_r[rd] = (a + b) % 16; m_c = (a + b > 15) ? 1 : 0; end
      OP_SUB: begin m_r[rd] = (a - b + 16) % 16; m_c = (a < b) ? 1 : 0; end
      OP_MUL: begin m_r[rd] = (a * b) % 16; m_hi = (a * b) / 16; end
      OP_AND: m_r[rd] = a & b;
      OP_OR:  m_r[rd] = a | b;
      OP_XOR: m_r[rd] = a ^ b;
      OP_LT:  m_lt = (a < b) ? 1 : 0;
      default: begin
`ifdef ALU_ISSUE_LDI_EN
        m_r[rd] = int'(imm);
`endif
      end
    endcase
  endtask

  task automatic check_state(input string tag);
    for (int j = 0; j < 4; j++) begin
      dbg_sel = 2'(j);
      #1;
      check($sformatf("%s r%0d", tag, j), 16'(dbg_data), 16'(m_r[j]));
    end
    check({tag, " hi"},      16'(hi),      16'(m_hi));
    check({tag, " flag_c"},  16'(flag_c),  16'(m_c));
    check({tag, " flag_lt"}, 16'(flag_lt), 16'(m_lt));
    check({tag, " alu_a"},   16'(alu_a),   16'(m_a));
    check({tag, " alu_b"},   16'(alu_b),   16'(m_b));
    check({tag, " alu_opn"}, 16'(alu_opn), 16'(m_op));
  endtask

  task automatic read_regs(output logic [15:0] v);
    for (int j = 0; j < 4; j++) begin
      dbg_sel = 2'(j);
      #1;
      v[4*j +: 4] = dbg_data;
    end
  endtask

  // Issue one instruction from IDLE, check ready/done timing, then the state.
  // With noise set, instr_valid stays high with junk through EXEC and WB.
  task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [3:0] imm, input logic noise,
                           input string tag);
    int lat;
    bit seen;
    check({tag, " ready before"}, 16'(instr_ready), 16'd1);
    instr       = enc(op, rd, rs1, rs2, imm, 3'($urandom));
    instr_valid = 1'b1;
    @(posedge clk); #1;
    model_exec(op, rd, rs1, rs2, imm);
    instr_valid = noise && (op != OP_LDI);
    instr       = 12'($urandom);
    lat  = 1;
    seen = 0;
    while (!seen && lat <= 4) begin
      if (done) begin
        seen = 1;
        check({tag, " ready at done"}, 16'(instr_ready), 16'(op == OP_LDI));
      end else begin
        check({tag, " ready busy"}, 16'(instr_ready), 16'd0);
        @(posedge clk); #1;
        lat++;
      end
    end
    check({tag, " done latency"}, 16'(seen ? lat : 99), 16'((op == OP_LDI) ? 1 : 2));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check({tag, " done one-shot"}, 16'(done), 16'd0);
    check_state(tag);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [$];
    logic [15:0] regs_act;

`ifdef ALU_ISSUE_LDI_EN
    tbl.push_back('{OP_LDI, 2'd1, 2'd0, 2'd0, 4'h9, 16'hCC9C, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{OP_LDI, 2'd2, 2'd0, 2'd0, 4'h8, 16'hC89C, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{OP_ADD, 2'd3, 2'd1, 2'd2, 4'h0, 16'h189C, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{OP_LDI, 2'd0, 2'd0, 2'd0, 4'h3, 16'h1893, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{OP_LDI, 2'd1, 2'd0, 2'd0, 4'h5, 16'h1853, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{OP_SUB, 2'd2, 2'd0, 2'd1, 4'h0, 16'h1E53, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{OP_LT,  2'd0, 2'd0, 2'd1, 4'h0, 16'h1E53, 4'h0, 1'b1, 1'b1});
    tbl.push_back('{OP_LDI, 2'd0, 2'd0, 2'd0, 4'h7, 16'h1E57, 4'h0, 1'b1, 1'b1});
    tbl.push_back('{OP_LDI, 2'd1, 2'd0, 2'd0, 4'h6, 16'h1E67, 4'h0, 1'b1, 1'b1});
    tbl.push_back('{OP_MUL, 2'd2, 2'd0, 2'd1, 4'h0, 16'h1A67, 4'h2, 1'b1, 1'b1});
    tbl.push_back('{OP_AND, 2'd3, 2'd2, 2'd1, 4'h0, 16'h2A67, 4'h2, 1'b1, 1'b1});
`else
    tbl.push_back('{OP_ADD, 2'd1, 2'd0, 2'd0, 4'h0, 16'hCC8C, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{OP_SUB, 2'd2, 2'd0, 2'd1, 4'h0, 16'hC48C, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{OP_MUL, 2'd3, 2'd2, 2'd0, 4'h0, 16'h048C, 4'h3, 1'b0, 1'b0});
    tbl.push_back('{OP_LT,  2'd0, 2'd2, 2'd1, 4'h0, 16'h048C, 4'h3, 1'b0, 1'b1});
    tbl.push_back('{OP_AND, 2'd0, 2'd0, 2'd1, 4'h0, 16'h0488, 4'h3, 1'b0, 1'b1});
    tbl.push_back('{OP_OR,  2'd3, 2'd2, 2'd1, 4'h0, 16'hC488, 4'h3, 1'b0, 1'b1});
    tbl.push_back('{OP_XOR, 2'd2, 2'd2, 2'd3, 4'h0, 16'hC888, 4'h3, 1'b0, 1'b1});
    tbl.push_back('{OP_LT,  2'd1, 2'd3, 2'd0, 4'h0, 16'hC888, 4'h3, 1'b0, 1'b0});
    tbl.push_back('{OP_ADD, 2'd3, 2'd3, 2'd2, 4'h0, 16'h4888, 4'h3, 1'b1, 1'b0});
    tbl.push_back('{OP_LDI, 2'd0, 2'd0, 2'd0, 4'h5, 16'h4888, 4'h3, 1'b1, 1'b0});
    tbl.push_back('{OP_SUB, 2'd0, 2'd3, 2'd0, 4'h0, 16'h488C, 4'h3, 1'b1, 1'b0});
    tbl.push_back('{OP_MUL, 2'd1, 2'd1, 2'd1, 4'h0, 16'h480C, 4'h4, 1'b1, 1'b0});
`endif

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("reset ready", 16'(instr_ready), 16'd1);
    check("reset done",  16'(done),        16'd0);
    check_state("reset");

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 1'b0,
                $sformatf("vec%0d", i));
      read_regs(regs_act);
      check($sformatf("vec%0d table regs", i), regs_act, tbl[i].regs);
      check($sformatf("vec%0d table hi", i), 16'(hi), 16'(tbl[i].hi));
      check($sformatf("vec%0d table c", i), 16'(flag_c), 16'(tbl[i].c));
      check($sformatf("vec%0d table lt", i), 16'(flag_lt), 16'(tbl[i].lt));
    end

    // instr_valid held high: a different instruction presented during EXEC/WB
    // is taken only once the block is back in IDLE.
    check("hold ready idle", 16'(instr_ready), 16'd1);
    instr       = enc(OP_ADD, 2'd3, 2'd0, 2'd1, 4'h0, 3'b101);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    model_exec(OP_ADD, 2'd3, 2'd0, 2'd1, 4'h0);
    check("hold ready exec", 16'(instr_ready), 16'd0);
    check("hold done exec",  16'(done),        16'd0);
    instr = enc(OP_XOR, 2'd0, 2'd0, 2'd0, 4'h0, 3'b000);
    @(posedge clk); #1;
    check("hold ready wb", 16'(instr_ready), 16'd0);
    check("hold done wb",  16'(done),        16'd1);
    @(posedge clk); #1;
    check("hold ready idle2", 16'(instr_ready), 16'd1);
    check("hold done idle2",  16'(done),        16'd0);
    @(posedge clk); #1;
    model_exec(OP_XOR, 2'd0, 2'd0, 2'd0, 4'h0);
    instr_valid = 1'b0;
    check("hold ready exec2", 16'(instr_ready), 16'd0);
    @(posedge clk); #1;
    check("hold done wb2", 16'(done), 16'd1);
    @(posedge clk); #1;
    check("hold done after", 16'(done), 16'd0);
    check_state("hold");

    // Reset during EXEC aborts the ADD
    instr       = enc(OP_ADD, 2'd3, 2'd0, 2'd1, 4'h0, 3'b000);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rst exec ready", 16'(instr_ready), 16'd1);
    check("rst exec done",  16'(done),        16'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst exec done later%0d", k), 16'(done), 16'd0);
    end
    check_state("rst exec");

    // Reset during WB aborts the SUB write-back and masks done
    instr       = enc(OP_SUB, 2'd2, 2'd0, 2'd3, 4'h0, 3'b000);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst wb done masked", 16'(done), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rst wb ready", 16'(instr_ready), 16'd1);
    check("rst wb done",  16'(done),        16'd0);
    check_state("rst wb");

    // Reset wins over a simultaneous accept
    rst         = 1'b1;
    instr       = enc(OP_ADD, 2'd1, 2'd0, 2'd0, 4'h0, 3'b000);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    instr_valid = 1'b0;
    model_reset();
    check("rst prio ready", 16'(instr_ready), 16'd1);
    @(posedge clk); #1;
    check("rst prio done",   16'(done),        16'd0);
    check("rst prio ready2", 16'(instr_ready), 16'd1);
    check_state("rst prio");

    // Randomized instruction stream against the model
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_instr(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom),
                4'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
